pulse_period_monitor: RTL and testbench

PULSE_PERIOD_MONITOR -- requirements
Module: pulse_period_monitor

---
 rtl/pulse_period_monitor_pkg.sv | 35 +++
 rtl/pulse_period_monitor_tick_div10.sv | 58 +++++
 rtl/pulse_period_monitor.sv | 193 +++++++++++++++++++
 tb/tb_pulse_period_monitor.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_period_monitor_pkg.sv
// -----------------------------------------------------------------------------
// pulse_period_monitor_pkg
//   Shared definitions for the pulse period monitor:
//     - default parameter values (0.1 s interval at 100 MHz, +/-1000 cycles)
//     - the monitor state encoding
//     - width of the saturating miss counter and of the decade counter
//     - a small saturating-increment helper
// -----------------------------------------------------------------------------
package pulse_period_monitor_pkg;

  localparam int NOMINAL_DEF = 10_000_000;
  localparam int TOL_DEF     = 1000;
  localparam int CNT_W_DEF   = 25;

  localparam int MISS_W      = 8;
  localparam int DECADE_W    = 4;

  // Monitor states. IDLE waits for the first pulse, ARM has a reference pulse
  // but no accepted interval yet, LOCK has at least one accepted interval,
  // LOST has timed out and waits for any pulse to re-arm.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    LOCK = 2'd2,
    LOST = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
    logic [MISS_W-1:0] r;
    r = (v == {MISS_W{1'b1}}) ? v : v + MISS_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/pulse_period_monitor_tick_div10.sv
// -----------------------------------------------------------------------------
// tick_div10
//   Decade counter over accepted intervals. Every tenth inc produces a
//   one-cycle registered tick and the count wraps to zero. clr has priority
//   and restarts the decade without producing a tick.
//
//   Ports:
//     clk    in  clock, posedge
//     rst_n  in  asynchronous active-low reset
//     inc    in  one accepted interval this cycle
//     clr    in  restart the decade (lock lost or re-armed)
//     tick   out registered strobe on the tenth inc
// -----------------------------------------------------------------------------
module tick_div10
  import pulse_period_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic tick
);

  logic [DECADE_W-1:0] count_q, count_d;
  logic                tick_q, tick_d;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q == DECADE_W'(9)) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + DECADE_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values computed before the edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pulse_period_monitor.sv
// -----------------------------------------------------------------------------
// pulse_period_monitor
//   Measures the interval between single-cycle pulses on pulse_in, accepts
//   intervals within NOMINAL +/- TOL, and reports lock, early pulses, missing
//   pulses (timeouts) and a 1-second tick derived from ten accepted intervals.
//
//   Parameters (legal only when TOL < NOMINAL and NOMINAL+TOL < 2**CNT_W):
//     NOMINAL  expected interval in clk cycles
//     TOL      allowed deviation either side, in cycles
//     CNT_W    width of the interval counter and of period
//
//   Ports:
//     clk           in   clock, posedge
//     rst_n         in   asynchronous active-low reset
//     pulse_in      in   single-cycle strobe, synchronous to clk
//     clear         in   clears early_err, late_err and miss_cnt
//     period        out  last accepted interval in cycles
//     period_valid  out  one-cycle strobe when period updates
//     locked        out  high while in LOCK
//     early_err     out  sticky: an interval was too short
//     late_err      out  sticky: a pulse went missing
//     miss_cnt      out  timeout count, saturating at 255
//     sec_tick      out  one-cycle strobe every ten accepted intervals
//
//   Interval measurement: cnt loads 0 on a pulse cycle and counts up every
//   following cycle, so the interval at the next pulse is N = cnt + 1.
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pulse_period_monitor
  import pulse_period_monitor_pkg::*;
#(
  parameter int NOMINAL = NOMINAL_DEF,
  parameter int TOL     = TOL_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clear,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic              locked,
  output logic              early_err,
  output logic              late_err,
  output logic [MISS_W-1:0] miss_cnt,
  output logic              sec_tick
);

  localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(NOMINAL + TOL);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic                locked_q, locked_d;
  logic                early_err_q, early_err_d;
  logic                late_err_q, late_err_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;

  // Interval length if a pulse were to arrive this cycle.
  logic [CNT_W-1:0]    n_cur;

  // One-cycle events decoded by the state machine.
  logic                ev_good;
  logic                ev_early;
  logic                ev_timeout;
  logic                ev_arm;

  assign n_cur = cnt_q + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State machine and interval counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    ev_good    = 1'b0;
    ev_early   = 1'b0;
    ev_timeout = 1'b0;
    ev_arm     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pulse_in) begin
          state_d = ARM;
          ev_arm  = 1'b1;
        end
      end

      ARM, LOCK: begin
        if (pulse_in) begin
          // A pulse always restarts the measurement. Intervals longer than
          // HI_LIM cannot reach here: the timeout below fires first, and a
          // pulse exactly on the HI_LIM cycle counts as good.
          cnt_d = '0;
          if (n_cur >= LO_LIM) begin
            ev_good  = 1'b1;
            period_d = n_cur;
            state_d  = LOCK;
          end else begin
            ev_early = 1'b1;
            state_d  = ARM;
          end
        end else if (n_cur == HI_LIM) begin
          // cnt is frozen from here on; LOST ignores it until a pulse re-arms.
          ev_timeout = 1'b1;
          state_d    = LOST;
        end else begin
          cnt_d = n_cur;
        end
      end

      LOST: begin
        if (pulse_in) begin
          cnt_d   = '0;
          state_d = ARM;
          ev_arm  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and sticky status
  // ---------------------------------------------------------------------------
  always_comb begin
    period_valid_d = ev_good;
    locked_d       = (state_d == LOCK);

    // clear is applied first so that an error event in the same cycle
    // overrides it: the flag stays set and miss_cnt restarts at 1.
    early_err_d = clear ? 1'b0 : early_err_q;
    late_err_d  = clear ? 1'b0 : late_err_q;
    miss_cnt_d  = clear ? '0   : miss_cnt_q;

    if (ev_early) begin
      early_err_d = 1'b1;
    end
    if (ev_timeout) begin
      late_err_d = 1'b1;
      miss_cnt_d = sat_inc_miss(miss_cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      early_err_q    <= 1'b0;
      late_err_q     <= 1'b0;
      miss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      early_err_q    <= early_err_d;
      late_err_q     <= late_err_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Decade counter: restarts whenever lock is abandoned or a new arm begins.
  // ---------------------------------------------------------------------------
  tick_div10 u_tick_div10 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ev_good),
    .clr   (ev_early | ev_timeout | ev_arm),
    .tick  (sec_tick)
  );

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign early_err    = early_err_q;
  assign late_err     = late_err_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_pulse_period_monitor
//   Scoreboard bench for pulse_period_monitor with NOMINAL=100, TOL=5.
//   The driver issues one input vector per clock edge and a reference model,
//   working from pulse timestamps (edge numbers), pushes the expected outputs
//   for that edge into a queue. A monitor on the falling edge pops and
//   compares; accepted periods go through a separate queue popped whenever
//   the DUT raises period_valid.
// -----------------------------------------------------------------------------
module tb_pulse_period_monitor;

  localparam int NOM   = 100;
  localparam int TOLP  = 5;
  localparam int CW    = 16;
  localparam int LO    = NOM - TOLP;
  localparam int HI    = NOM + TOLP;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_LOCK = 2;
  localparam int M_LOST = 3;

  typedef struct {
    int idx;
    int period;
    bit pv;
    bit tick;
    bit locked;
    bit early;
    bit late;
    int miss;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          pulse_in;
  logic          clear;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          early_err;
  logic          late_err;
  logic [7:0]    miss_cnt;
  logic          sec_tick;

  pulse_period_monitor #(
    .NOMINAL (NOM),
    .TOL     (TOLP),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .clear        (clear),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .early_err    (early_err),
    .late_err     (late_err),
    .miss_cnt     (miss_cnt),
    .sec_tick     (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_failures = 0;
  int n_edge     = 0;

  always @(posedge clk) n_edge++;

  exp_t st_q[$];
  int   per_q[$];

  // Reference model state: mode, edge number of the reference pulse, count of
  // accepted intervals since the last arm, and the expected output registers.
  int m_mode, m_ref, m_good, m_period, m_miss;
  bit m_early, m_late;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_ref    = 0;
    m_good   = 0;
    m_period = 0;
    m_miss   = 0;
    m_early  = 1'b0;
    m_late   = 1'b0;
  endtask

  task automatic push_expect(input int k, input bit pv, input bit tick);
    exp_t e;
    e.idx    = k;
    e.period = m_period;
    e.pv     = pv;
    e.tick   = tick;
    e.locked = (m_mode == M_LOCK);
    e.early  = m_early;
    e.late   = m_late;
    e.miss   = m_miss;
    st_q.push_back(e);
  endtask

  // Expected effect of the next clock edge given this cycle's inputs.
  task automatic model_edge(input bit p, input bit c);
    int k, n;
    bit pv, tick;
    k    = n_edge + 1;
    pv   = 1'b0;
    tick = 1'b0;
    if (c) begin
      m_early = 1'b0;
      m_late  = 1'b0;
      m_miss  = 0;
    end
    if (m_mode == M_IDLE || m_mode == M_LOST) begin
      if (p) begin
        m_mode = M_ARM;
        m_ref  = k;
        m_good = 0;
      end
    end else begin
      n = k - m_ref;
      if (p) begin
        if (n >= LO && n <= HI) begin
          m_period = n;
          pv       = 1'b1;
          m_mode   = M_LOCK;
          m_good++;
          tick     = (m_good % 10 == 0);
          per_q.push_back(n);
        end else begin
          m_early = 1'b1;
          m_mode  = M_ARM;
          m_good  = 0;
        end
        m_ref = k;
      end else if (n == HI) begin
        m_late = 1'b1;
        if (m_miss < 255) m_miss++;
        m_mode = M_LOST;
        m_good = 0;
      end
    end
    push_expect(k, pv, tick);
  endtask

  // One clock of stimulus; called at posedge+2, returns at the next posedge+2.
  task automatic step(input bit p, input bit c);
    pulse_in = p;
    clear    = c;
    model_edge(p, c);
    @(posedge clk);
    #2;
  endtask

  // Pulse arriving n cycles after the previous step's reference.
  task automatic interval(input int n, input bit rand_clr);
    bit c;
    for (int i = 1; i < n; i++) begin
      c = rand_clr && ($urandom_range(0, 63) == 0);
      step(1'b0, c);
    end
    c = rand_clr && ($urandom_range(0, 63) == 0);
    step(1'b1, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"},       32'(period),       32'd0);
    check({tag, "_period_valid"}, 32'(period_valid), 32'd0);
    check({tag, "_locked"},       32'(locked),       32'd0);
    check({tag, "_early_err"},    32'(early_err),    32'd0);
    check({tag, "_late_err"},     32'(late_err),     32'd0);
    check({tag, "_miss_cnt"},     32'(miss_cnt),     32'd0);
    check({tag, "_sec_tick"},     32'(sec_tick),     32'd0);
  endtask

  // Asynchronous reset pulse held across one edge, issued after the monitor
  // has sampled the current cycle.
  task automatic reset_pulse();
    pulse_in = 1'b0;
    clear    = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    push_expect(n_edge + 1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every edge's outputs against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   p;
    while (st_q.size() > 0 && st_q[0].idx < n_edge) begin
      e = st_q.pop_front();
      check("scoreboard_skipped_edge", 32'(e.idx), 32'(n_edge));
    end
    if (st_q.size() > 0 && st_q[0].idx == n_edge) begin
      e = st_q.pop_front();
      check("period_valid", 32'(period_valid), 32'(e.pv));
      check("sec_tick",     32'(sec_tick),     32'(e.tick));
      check("locked",       32'(locked),       32'(e.locked));
      check("early_err",    32'(early_err),    32'(e.early));
      check("late_err",     32'(late_err),     32'(e.late));
      check("miss_cnt",     32'(miss_cnt),     32'(e.miss));
      check("period_reg",   32'(period),       32'(e.period));
      if (period_valid) begin
        if (per_q.size() == 0) begin
          check("unexpected_period_valid", 32'd1, 32'd0);
        end else begin
          p = per_q.pop_front();
          check("period_on_valid", 32'(period), 32'(p));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    pulse_in = 1'b0;
    clear    = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset_state");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Steady pulses at the nominal interval: lock, then ticks every 10.
    idle(7);
    step(1'b1, 1'b0);
    interval(NOM, 1'b0);
    check("first_period", 32'(period), 32'd100);
    check("first_lock",   32'(locked), 32'd1);
    for (int i = 0; i < 20; i++) interval(NOM, 1'b0);

    // Short interval while locked, then relock.
    interval(94, 1'b0);
    check("early_flag",    32'(early_err), 32'd1);
    check("early_unlock",  32'(locked),    32'd0);
    check("early_period",  32'(period),    32'd100);
    interval(NOM, 1'b0);
    check("relock",        32'(locked),    32'd1);

    // Tolerance boundaries, then a pulse that arrives after the timeout.
    interval(95, 1'b0);
    check("boundary_lo", 32'(period), 32'd95);
    interval(105, 1'b0);
    check("boundary_hi", 32'(period), 32'd105);
    interval(106, 1'b0);
    check("late_flag",   32'(late_err), 32'd1);
    check("late_miss",   32'(miss_cnt), 32'd1);
    check("late_period", 32'(period),   32'd105);
    check("late_locked", 32'(locked),   32'd0);
    interval(NOM, 1'b0);
    step(1'b0, 1'b1);
    idle(3);

    // Three timeouts, then clear on the cycle of a fourth.
    for (int i = 0; i < 3; i++) interval(106, 1'b0);
    check("miss_three", 32'(miss_cnt), 32'd3);
    idle(HI - 1);
    step(1'b0, 1'b1);
    check("clear_vs_timeout_flag", 32'(late_err), 32'd1);
    check("clear_vs_timeout_miss", 32'(miss_cnt), 32'd1);

    // Reset mid-interval while locked; two pulses are needed to relock.
    step(1'b1, 1'b0);
    interval(NOM, 1'b0);
    idle(50);
    reset_pulse();
    idle(4);
    step(1'b1, 1'b0);
    check("after_reset_arm_only", 32'(locked), 32'd0);
    interval(NOM, 1'b0);
    check("after_reset_relock", 32'(locked), 32'd1);
    check("after_reset_period", 32'(period), 32'd100);

    // Saturate the miss counter.
    for (int i = 0; i < 260; i++) interval(106, 1'b0);
    check("miss_saturated", 32'(miss_cnt), 32'd255);
    step(1'b0, 1'b1);

    // Randomised intervals with occasional clears.
    for (int i = 0; i < 150; i++) begin
      int r, g;
      r = $urandom_range(0, 9);
      if (r < 6)      g = $urandom_range(LO, HI);
      else if (r < 8) g = $urandom_range(60, LO - 1);
      else            g = $urandom_range(HI + 1, 130);
      interval(g, 1'b1);
    end
    idle(3);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(st_q.size()),  32'd0);
    check("periods_drained",    32'(per_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
